cz_flag_unit: RTL and testbench
===============================

# cz_flag_unit

Owns the carry (C) and zero (Z) condition flags of the pipelined core. It tracks the flag writes of instructions in flight from EX through MEM and WB, and commits them to the architectural flag registers at WB. It forwards the newest flag values to the conditional-execution logic in EX, so a conditional R-type instruction sees the flags produced by the instruction immediately ahead of it.

## Interface
Parameters:
- none; flag width is fixed at 1 bit each.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: back-end freeze; all flag state holds.
- `flush` in 1: kill the instruction currently in EX; it is not captured.
- `ex_valid` in 1: EX holds a live instruction. Nullified (NOP-converted) instructions present 0.
- `ex_c_we` in 1: EX instruction writes C.
- `ex_z_we` in 1: EX instruction writes Z.
- `ex_carry` in 1: C value from the ALU.
- `ex_zero` in 1: Z value from the ALU.
- `ex_ld_z` in 1: EX instruction is a load that writes Z. Its Z is resolved in MEM.
- `mem_ld_zero` in 1: zero test of the load data, valid while the MEM entry has `ld_z` set.
- `carry` out 1: forwarded C seen by the EX instruction.
- `zero` out 1: forwarded Z seen by the EX instruction.
- `arch_carry` out 1: committed C.
- `arch_zero` out 1: committed Z.
- `pend_c` out 1: a C write is in flight in MEM or WB.
- `pend_z` out 1: a Z write is in flight in MEM or WB.

## Operation
- Pipeline entries: MEM and WB. Each entry holds {valid, c_we, z_we, c, z, ld_z}.
- Edge with `stall`=0:
  - MEM is loaded from the EX inputs when `ex_valid`=1 and `flush`=0; otherwise MEM becomes invalid.
  - WB is loaded from MEM. If MEM.ld_z=1, WB.z = `mem_ld_zero`.
  - If WB is valid, it commits: `arch_carry` updates when WB.c_we=1, `arch_zero` updates when WB.z_we=1.
- Edge with `stall`=1: MEM, WB and the architectural flags all hold. `flush` is ignored, so stall wins if both are asserted.
- Forwarding is combinational and done per flag independently. Priority, newest first:
  1. MEM entry, if valid and writing that flag. For Z with ld_z=1, the value is `mem_ld_zero`.
  2. WB entry, if valid and writing that flag.
  3. The architectural flag.
- An EX instruction never sees its own write.
- `ex_ld_z`=1 implies `ex_z_we`=1. If `ex_z_we`=0, `ex_ld_z` is ignored.
- `pend_c` = (MEM.valid & MEM.c_we) | (WB.valid & WB.c_we). `pend_z` is formed the same way with z_we.
- Reset: MEM and WB invalid; `arch_carry`=`arch_zero`=0. Therefore `carry`, `zero`, `pend_c` and `pend_z` are all 0 the cycle after reset. `rst` overrides `stall` and `flush`.
- Reset mid-operation discards in-flight writes. Nothing commits on the reset edge.

## Timing
- EX to forwarded output: 1 edge. A write captured at edge N is visible on `carry`/`zero` after edge N.
- EX to architectural: 3 edges (into MEM, into WB, commit).
- Load Z is sampled from `mem_ld_zero` at the MEM→WB edge.
- Back-to-back flag writers are allowed. MEM and WB may both write the same flag; MEM wins when forwarding, and WB commits first.
- No stall is ever generated by this block.

## Structure
- Shared package `cz_pkg`:
  - typedef `cz_entry_t` {valid, c_we, z_we, c, z, ld_z}.
  - constant `CZ_ENTRY_RESET` (all zero).
- Sub-module `cz_flag_stage`: one entry register with stall hold, kill and reset. Instantiated for MEM and WB.
- Top level `cz_flag_unit` contains the load-Z merge, forwarding muxes, architectural registers and pend logic.

## Test plan
- Reset, then drive nothing:
  - `carry`=`zero`=`arch_*`=`pend_*`=0.
  - Assert `rst` with `stall`=1; state still clears.
- ADD with C=1, Z=0 (`ex_c_we`=`ex_z_we`=1) at edge 1:
  - After edge 1: `carry`=1, `zero`=0, `pend_c`=`pend_z`=1.
  - `arch_carry`=1 only after edge 3; `pend_*`=0 after edge 3.
- Back-to-back writers:
  - Writer A sets C=1 only; writer B, one edge later, sets Z=1 only.
  - After B captures: `carry`=1 (from WB) and `zero`=1 (from MEM).
- Load-Z:
  - Load with `ex_ld_z`=1 and `ex_zero`=0, then `mem_ld_zero`=1 while in MEM.
  - `zero`=1 during the MEM cycle; `arch_zero`=1 two edges later.
- Flush and stall:
  - Writer with C=1 and `flush`=1: `carry` stays 0.
  - Writer in MEM with `stall`=1 for 3 cycles: `carry` holds 1, `arch_carry` holds 0, commit delayed by 3 edges.
  - `stall`=`flush`=1 together: the entry is retained.
- Nullified instruction:
  - `ex_valid`=0 with `ex_c_we`=1 and `ex_carry`=1: no change to `carry`, `arch_carry` or `pend_c`.

Source files
------------

// File: rtl/cz_pkg.sv
// Shared types for the carry/zero flag pipeline.
//   cz_entry_t     : one in-flight flag write (MEM or WB slot)
//   CZ_ENTRY_RESET : empty/invalid entry
package cz_pkg;

    typedef struct packed {
        logic valid;
        logic c_we;
        logic z_we;
        logic c;
        logic z;
        logic ld_z;
    } cz_entry_t;

    localparam cz_entry_t CZ_ENTRY_RESET = '0;

endpackage

// File: rtl/cz_flag_stage.sv
// One pipeline entry register for the flag unit.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears entry, beats stall)
//   stall_i : hold current entry
//   kill_i  : load an empty entry instead of d_i
//   d_i     : entry to capture
//   q_o     : registered entry
module cz_flag_stage
    import cz_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      stall_i,
    input  logic      kill_i,
    input  cz_entry_t d_i,
    output cz_entry_t q_o
);

    cz_entry_t entry_q;
    cz_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (!stall_i) begin
            entry_d = kill_i ? CZ_ENTRY_RESET : d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= CZ_ENTRY_RESET;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/cz_flag_unit.sv
// Carry/zero flag owner: tracks in-flight flag writes in MEM and WB,
// commits them at WB and forwards the newest values to EX.
//   clk, rst          : clock, synchronous active-high reset
//   stall, flush      : back-end freeze; kill of the EX instruction
//   ex_valid          : EX holds a live instruction
//   ex_c_we, ex_z_we  : EX instruction writes C / Z
//   ex_carry, ex_zero : ALU flag values
//   ex_ld_z           : EX load whose Z is resolved in MEM
//   mem_ld_zero       : zero test of load data while in MEM
//   carry, zero       : forwarded flags seen in EX
//   arch_carry/zero   : committed flags
//   pend_c, pend_z    : a write to C / Z is in MEM or WB
module cz_flag_unit
    import cz_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic flush,
    input  logic ex_valid,
    input  logic ex_c_we,
    input  logic ex_z_we,
    input  logic ex_carry,
    input  logic ex_zero,
    input  logic ex_ld_z,
    input  logic mem_ld_zero,
    output logic carry,
    output logic zero,
    output logic arch_carry,
    output logic arch_zero,
    output logic pend_c,
    output logic pend_z
);

    cz_entry_t ex_entry;
    cz_entry_t mem_q;
    cz_entry_t mem_fwd;
    cz_entry_t wb_q;

    logic arch_c_q, arch_c_d;
    logic arch_z_q, arch_z_d;

    // ld_z only meaningful when the instruction actually writes Z
    always_comb begin
        ex_entry       = CZ_ENTRY_RESET;
        ex_entry.valid = ex_valid;
        ex_entry.c_we  = ex_c_we;
        ex_entry.z_we  = ex_z_we;
        ex_entry.c     = ex_carry;
        ex_entry.z     = ex_zero;
        ex_entry.ld_z  = ex_ld_z & ex_z_we;
    end

    cz_flag_stage u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .kill_i  (~ex_valid | flush),
        .d_i     (ex_entry),
        .q_o     (mem_q)
    );

    // Load Z resolves here; the merged value feeds both forwarding and WB
    always_comb begin
        mem_fwd = mem_q;
        if (mem_q.ld_z) begin
            mem_fwd.z = mem_ld_zero;
        end
    end

    cz_flag_stage u_wb (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .kill_i  (1'b0),
        .d_i     (mem_fwd),
        .q_o     (wb_q)
    );

    always_comb begin
        arch_c_d = arch_c_q;
        arch_z_d = arch_z_q;
        if (!stall && wb_q.valid) begin
            if (wb_q.c_we) arch_c_d = wb_q.c;
            if (wb_q.z_we) arch_z_d = wb_q.z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arch_c_q <= 1'b0;
            arch_z_q <= 1'b0;
        end else begin
            arch_c_q <= arch_c_d;
            arch_z_q <= arch_z_d;
        end
    end

    always_comb begin
        if (mem_fwd.valid && mem_fwd.c_we)     carry = mem_fwd.c;
        else if (wb_q.valid && wb_q.c_we)      carry = wb_q.c;
        else                                   carry = arch_c_q;

        if (mem_fwd.valid && mem_fwd.z_we)     zero = mem_fwd.z;
        else if (wb_q.valid && wb_q.z_we)      zero = wb_q.z;
        else                                   zero = arch_z_q;
    end

    assign arch_carry = arch_c_q;
    assign arch_zero  = arch_z_q;
    assign pend_c     = (mem_q.valid & mem_q.c_we) | (wb_q.valid & wb_q.c_we);
    assign pend_z     = (mem_q.valid & mem_q.z_we) | (wb_q.valid & wb_q.z_we);

endmodule

// File: tb/tb_cz_flag_unit.sv
// Scoreboard bench for cz_flag_unit: stimulus pushes the expected outputs
// of each cycle, a monitor pops and compares them on the falling edge.
module tb_cz_flag_unit;

    logic clk = 1'b0;
    logic rst, stall, flush, ex_valid, ex_c_we, ex_z_we, ex_carry, ex_zero;
    logic ex_ld_z, mem_ld_zero;
    logic carry, zero, arch_carry, arch_zero, pend_c, pend_z;

    always #5 clk = ~clk;

    cz_flag_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_c_we     (ex_c_we),
        .ex_z_we     (ex_z_we),
        .ex_carry    (ex_carry),
        .ex_zero     (ex_zero),
        .ex_ld_z     (ex_ld_z),
        .mem_ld_zero (mem_ld_zero),
        .carry       (carry),
        .zero        (zero),
        .arch_carry  (arch_carry),
        .arch_zero   (arch_zero),
        .pend_c      (pend_c),
        .pend_z      (pend_z)
    );

    // Reference model: list of in-flight flag writers, oldest first,
    // each tagged with the advance tick at which it was captured.
    typedef struct {
        bit          cwe, zwe, c, z, ldz;
        int unsigned t;
    } rec_t;

    rec_t        flight[$];
    int unsigned adv = 0;
    bit          m_ac = 0, m_az = 0;
    bit          known = 0;

    // expected {carry, zero, arch_carry, arch_zero, pend_c, pend_z}
    logic [5:0]  exp_q[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic cycle(input bit r, input bit s, input bit f, input bit v,
                         input bit cwe, input bit zwe, input bit c, input bit z,
                         input bit ldz, input bit mlz);
        bit fc, fz, fcf, fzf, pc, pz;
        rec_t nr;
        rec_t keep[$];
        @(posedge clk);
        #1;
        rst = r; stall = s; flush = f; ex_valid = v; ex_c_we = cwe;
        ex_z_we = zwe; ex_carry = c; ex_zero = z; ex_ld_z = ldz;
        mem_ld_zero = mlz;
        cyc++;

        if (known) begin
            fc = m_ac; fz = m_az; fcf = 0; fzf = 0; pc = 0; pz = 0;
            for (int i = flight.size() - 1; i >= 0; i--) begin
                bit in_mem;
                in_mem = (adv == flight[i].t);
                if (flight[i].cwe) begin
                    pc = 1;
                    if (!fcf) begin fc = flight[i].c; fcf = 1; end
                end
                if (flight[i].zwe) begin
                    pz = 1;
                    if (!fzf) begin
                        fz = (in_mem && flight[i].ldz) ? mlz : flight[i].z;
                        fzf = 1;
                    end
                end
            end
            exp_q.push_back({fc, fz, m_ac, m_az, pc, pz});
        end

        // advance the model to the state after the coming edge
        if (r) begin
            flight.delete();
            m_ac = 0; m_az = 0;
            known = 1;
        end else if (!s) begin
            keep.delete();
            foreach (flight[i]) begin
                rec_t e;
                e = flight[i];
                if (adv - e.t == 1) begin
                    if (e.cwe) m_ac = e.c;
                    if (e.zwe) m_az = e.z;
                end else begin
                    if (e.ldz && e.zwe) e.z = mlz;
                    keep.push_back(e);
                end
            end
            flight = keep;
            adv++;
            if (v && !f) begin
                nr.cwe = cwe; nr.zwe = zwe; nr.c = c; nr.z = z;
                nr.ldz = ldz; nr.t = adv;
                flight.push_back(nr);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e, a;
            e = exp_q.pop_front();
            a = {carry, zero, arch_carry, arch_zero, pend_c, pend_z};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL flags cyc=%0d got c,z,ac,az,pc,pz=%b want=%b",
                         cyc, a, e);
            end
        end
    end

    initial begin
        rst = 1; stall = 0; flush = 0; ex_valid = 0; ex_c_we = 0; ex_z_we = 0;
        ex_carry = 0; ex_zero = 0; ex_ld_z = 0; mem_ld_zero = 0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // reset while stalled, with a writer in flight
        cycle(0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // ADD C=1 Z=0
        cycle(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        idle(4);
        // back-to-back: A writes C=1, B writes Z=1
        cycle(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        idle(4);
        // clear flags, then load-Z resolved in MEM
        cycle(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        idle(3);
        cycle(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // flushed writer
        cycle(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        idle(4);
        cycle(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        idle(3);
        // writer held in MEM by a 3-cycle stall
        cycle(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // stall and flush together: MEM entry retained
        cycle(0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        cycle(0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        idle(4);
        // nullified writer
        cycle(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            bit zwe;
            zwe = $urandom_range(0, 1);
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1),
                  zwe,
                  $urandom_range(0, 1),
                  $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1));
        end
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        if (total < 12) begin
            bad++;
            $display("FAIL count checks=%0d want>=12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
